// File: rtl/pc_unit.sv
// Program-counter unit: registered PC with next-PC selection between sequential, branch,
// jump, call and return, backed by a small circular return-address stack.
module pc_unit #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned INC       = 1,
  parameter int unsigned OFF_W     = 8,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [OFF_W-1:0]  br_off_i,
  input  logic              jmp_i,
  input  logic              call_i,
  input  logic              ret_i,
  input  logic [PC_W-1:0]   jmp_tgt_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [PC_W-1:0]   pc_next_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              ras_err_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [PC_W-1:0]  INC_V    = PC_W'(INC);
  localparam logic [PC_W-1:0]  RST_V    = PC_W'(RESET_PC);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d, top_inc, top_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             push;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  off_ext;

  // Offset is sign-extended, or truncated when wider than the PC.
  if (OFF_W >= PC_W) begin : g_off_trunc
    assign off_ext = br_off_i[PC_W-1:0];
  end else begin : g_off_sext
    assign off_ext = {{(PC_W - OFF_W){br_off_i[OFF_W-1]}}, br_off_i};
  end

  assign pc_inc = pc_q + INC_V;

  always_comb begin
    top_inc = (top_q == PTR_LAST) ? '0 : top_q + PTR_W'(1);
    top_dec = (top_q == '0) ? PTR_LAST : top_q - PTR_W'(1);

    pc_next_o = pc_inc;
    top_d     = top_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    push      = 1'b0;

    if (rst) begin
      pc_next_o = RST_V;
      top_d     = '0;
      cnt_d     = '0;
      err_d     = 1'b0;
    end else if (stall_i) begin
      pc_next_o = pc_q;
    end else if (ret_i) begin
      if (cnt_q != '0) begin
        pc_next_o = ras_q[top_q];
        top_d     = top_dec;
        cnt_d     = cnt_q - CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (call_i) begin
      pc_next_o = jmp_tgt_i;
      push      = 1'b1;
      top_d     = top_inc;
      // A full stack wraps onto its oldest entry; depth saturates.
      if (cnt_q == CNT_MAX) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (jmp_i) begin
      pc_next_o = jmp_tgt_i;
    end else if (br_taken_i) begin
      pc_next_o = pc_q + off_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RST_V;
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_next_o;
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack entries carry no reset; only pointer and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_q[top_inc] <= pc_inc;
    end
  end

  assign pc_o        = pc_q;
  assign ras_empty_o = (cnt_q == '0);
  assign ras_full_o  = (cnt_q == CNT_MAX);
  assign ras_err_o   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a reference model predicts each cycle's result, which is queued on drive
// and popped for comparison after the clock edge.
module tb_pc_unit;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned OFF_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  RST_PC = 8'h00;

  typedef struct {
    logic [7:0] pc;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, stall_i, br_taken_i, jmp_i, call_i, ret_i;
  logic [7:0] br_off_i, jmp_tgt_i;
  logic [7:0] pc_o, pc_next_o;
  logic       ras_empty_o, ras_full_o, ras_err_o;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  exp_t       sb_q[$];
  logic [7:0] m_stack[$];
  logic [7:0] m_pc;
  logic       m_err;

  always #5 clk = ~clk;

  pc_unit #(
    .PC_W      (PC_W),
    .INC       (1),
    .OFF_W     (OFF_W),
    .RESET_PC  (0),
    .RAS_DEPTH (DEPTH)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_off_i    (br_off_i),
    .jmp_i       (jmp_i),
    .call_i      (call_i),
    .ret_i       (ret_i),
    .jmp_tgt_i   (jmp_tgt_i),
    .pc_o        (pc_o),
    .pc_next_o   (pc_next_o),
    .ras_empty_o (ras_empty_o),
    .ras_full_o  (ras_full_o),
    .ras_err_o   (ras_err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; stall_i = 1'b0; br_taken_i = 1'b0; jmp_i = 1'b0;
    call_i = 1'b0; ret_i = 1'b0; br_off_i = 8'h00; jmp_tgt_i = 8'h00;
  endtask

  // One clock with the currently driven inputs; inputs are cleared afterwards.
  task automatic cycle(input string tag);
    logic [7:0] npc;
    exp_t       e;
    exp_t       got;
    #1;
    if (rst) begin
      npc = RST_PC;
      m_stack.delete();
      m_err = 1'b0;
    end else if (stall_i) begin
      npc = m_pc;
    end else if (ret_i) begin
      if (m_stack.size() > 0) begin
        npc = m_stack.pop_back();
      end else begin
        npc   = m_pc + 8'd1;
        m_err = 1'b1;
      end
    end else if (call_i) begin
      npc = jmp_tgt_i;
      if (m_stack.size() == DEPTH) begin
        void'(m_stack.pop_front());
        m_err = 1'b1;
      end
      m_stack.push_back(m_pc + 8'd1);
    end else if (jmp_i) begin
      npc = jmp_tgt_i;
    end else if (br_taken_i) begin
      // PC_W == OFF_W here, so 8-bit wrapping add equals sign-extended add.
      npc = m_pc + br_off_i;
    end else begin
      npc = m_pc + 8'd1;
    end
    check_eq({tag, ".pc_next"}, 32'(pc_next_o), 32'(npc));
    e.pc    = npc;
    e.empty = (m_stack.size() == 0);
    e.full  = (m_stack.size() == DEPTH);
    e.err   = m_err;
    sb_q.push_back(e);
    m_pc = npc;

    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq({tag, ".pc"},    32'(pc_o),        32'(got.pc));
    check_eq({tag, ".empty"}, 32'(ras_empty_o), 32'(got.empty));
    check_eq({tag, ".full"},  32'(ras_full_o),  32'(got.full));
    check_eq({tag, ".err"},   32'(ras_err_o),   32'(got.err));
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_jmp(input logic [7:0] tgt, input string tag);
    jmp_i = 1'b1; jmp_tgt_i = tgt;
    cycle(tag);
  endtask

  task automatic do_call(input logic [7:0] tgt, input string tag);
    call_i = 1'b1; jmp_tgt_i = tgt;
    cycle(tag);
  endtask

  task automatic do_ret(input string tag);
    ret_i = 1'b1;
    cycle(tag);
  endtask

  task automatic do_br(input logic [7:0] off, input string tag);
    br_taken_i = 1'b1; br_off_i = off;
    cycle(tag);
  endtask

  initial begin
    m_pc  = 8'h00;
    m_err = 1'b0;
    clear_inputs();
    @(negedge clk);

    // Reset then sequential advance; explicit pc checks against the plan values.
    rst = 1'b1; cycle("rst0");
    rst = 1'b1; cycle("rst1");
    check_eq("rst_pc", 32'(pc_o), 32'h00);
    cycle("seq1");
    cycle("seq2");
    cycle("seq3");
    check_eq("seq3_pc", 32'(pc_o), 32'h03);

    do_jmp(8'hFF, "jmp_ff");
    cycle("wrap");
    check_eq("wrap_pc", 32'(pc_o), 32'h00);

    // Branches, including negative offset and wrap.
    do_jmp(8'h10, "jmp_10");
    do_br(8'hFC, "br_neg");
    check_eq("br_neg_pc", 32'(pc_o), 32'h0C);
    do_jmp(8'hFE, "jmp_fe");
    do_br(8'h05, "br_wrap");
    check_eq("br_wrap_pc", 32'(pc_o), 32'h03);

    // Stall beats jump; jump beats branch.
    stall_i = 1'b1; jmp_i = 1'b1; jmp_tgt_i = 8'h40;
    cycle("stall");
    check_eq("stall_pc", 32'(pc_o), 32'h03);
    jmp_i = 1'b1; jmp_tgt_i = 8'h40; br_taken_i = 1'b1; br_off_i = 8'h07;
    cycle("jmp_over_br");
    check_eq("jmp_over_br_pc", 32'(pc_o), 32'h40);

    // Single call/return.
    do_jmp(8'h20, "jmp_20");
    do_call(8'h80, "call_80");
    cycle("adv81"); cycle("adv82"); cycle("adv83");
    do_ret("ret_21");
    check_eq("ret_21_pc", 32'(pc_o), 32'h21);
    check_eq("ret_21_empty", 32'(ras_empty_o), 32'h1);

    // Overflow: five nested calls into a four-deep stack.
    do_jmp(8'h00, "jmp_00");
    for (int i = 1; i <= 5; i++) begin
      do_call(8'(i * 16), $sformatf("ncall%0d", i));
    end
    check_eq("ovf_full", 32'(ras_full_o), 32'h1);
    check_eq("ovf_err",  32'(ras_err_o),  32'h1);
    for (int i = 0; i < 4; i++) begin
      do_ret($sformatf("nret%0d", i));
      check_eq($sformatf("nret%0d_pc", i), 32'(pc_o), 32'(8'h41 - 8'(i * 16)));
    end
    do_ret("underflow");
    check_eq("underflow_pc",  32'(pc_o),      32'h12);
    check_eq("underflow_err", 32'(ras_err_o), 32'h1);

    // Reset in the middle of stack activity, then underflow after reset.
    do_jmp(8'h00, "jmp_00b");
    do_call(8'h10, "rcall1");
    do_call(8'h20, "rcall2");
    rst = 1'b1; ret_i = 1'b1;
    cycle("rst_ret");
    check_eq("rst_ret_pc",    32'(pc_o),        32'h00);
    check_eq("rst_ret_empty", 32'(ras_empty_o), 32'h1);
    check_eq("rst_ret_err",   32'(ras_err_o),   32'h0);
    do_ret("post_rst_ret");
    check_eq("post_rst_err", 32'(ras_err_o), 32'h1);

    // Simultaneous call and return: return wins, no push.
    do_call(8'h50, "cr_call");
    call_i = 1'b1; ret_i = 1'b1; jmp_tgt_i = 8'h90;
    cycle("call_ret");
    check_eq("call_ret_pc",    32'(pc_o),        32'h02);
    check_eq("call_ret_empty", 32'(ras_empty_o), 32'h1);

    check_eq("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
